alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, handshaked successor of the sequential byte ALU. It accepts one signed operation per transfer via valid/ready and supports ADD, SUB, MULT and DIV at WIDTH bits, with a per-transaction wrap/saturate mode and overflow and divide-by-zero flags. ADD, SUB and MULT complete in one cycle. DIV uses an iterative sub-module. It sits between the operand-issue logic and the result consumer, and stalls cleanly under backpressure.

Parameters:
WIDTH, 8, operand/result width in bits (signed two's complement, >= 4)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept request this cycle
in_opcode  in  2  opcode_e: ADD=0, SUB=1, MULT=2, DIV=3
in_sat  in  1  1 = saturate on overflow, 0 = wrap (low WIDTH bits)
in_a  in  WIDTH  signed operand 1
in_b  in  WIDTH  signed operand 2
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  signed result
out_ovf  out  1  true result not representable in WIDTH bits (set in both modes)
out_err  out  1  divide by zero

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ovf=0, out_err=0, FSM=IDLE. in_ready goes low while rst is asserted.
- Reset mid-division aborts the division. No result is produced.
- Request transfer: in_valid && in_ready at a rising edge. Result transfer: out_valid && out_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput when out_ready=1.
- out_data, out_ovf and out_err stay stable while out_valid=1 && out_ready=0.
- out_valid drops after a result transfer unless a new result loads on the same edge.
- FSM states:
  - IDLE: an accepted ADD, SUB or MULT loads the output register; latency 1 cycle. An accepted DIV with in_b!=0 goes to DIV_BUSY and starts the divider. An accepted DIV with in_b==0 loads out_data=0, out_err=1, out_ovf=0; latency 1.
  - DIV_BUSY: the divider runs WIDTH iterations, one quotient bit per cycle. Then go to DIV_DONE.
  - DIV_DONE: apply sign fix and saturation. Load the output register when it is empty or being drained, then go to IDLE. Otherwise stay in DIV_DONE.
- DIV latency with no backpressure: out_valid rises WIDTH+1 cycles after the accept edge (9 for WIDTH=8). in_ready is 0 throughout.
- Arithmetic is computed at full precision: WIDTH+1 bits for ADD/SUB, 2*WIDTH bits for MULT.
  - ovf = the result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Wrap mode: out_data = low WIDTH bits.
  - Saturate mode: clamp to MIN or MAX according to the true sign.
- DIV: signed quotient truncated toward zero (matches the SV '/' operator). The divider works on magnitudes; the sign is applied in DIV_DONE.
  - MIN / -1 sets ovf=1. Wrap mode gives MIN; saturate mode gives MAX.
- out_err=1 only for divide by zero; it is 0 otherwise. out_ovf=0 whenever out_err=1.
- in_opcode, in_sat and the operands are sampled only on the accept edge. Changes while stalled are ignored.

Decomposition:
- Package alu_pkg: opcode_e (2-bit, values above), alu_state_e {IDLE, DIV_BUSY, DIV_DONE}, and functions sat_clamp and sign_fix parametrised by width argument.
- Sub-module alu_div_seq (param WIDTH): unsigned restoring divider.
  - Ports: clk, rst, start, dividend, divisor, busy, done, quotient.
  - done pulses after exactly WIDTH cycles.
- Top level holds the FSM, the single-cycle datapath and the output register.

Test Plan:
1. Reset mid-division: start DIV 100/3, assert rst after 4 cycles -> out_valid=0, out_data=0, in_ready=1 after release; next ADD 1+1 returns 2 with latency 1.
2. ADD 100+50 (WIDTH=8) -> in_sat=0: out_data=-106, ovf=1; in_sat=1: out_data=127, ovf=1. SUB -100-50 with sat -> -128, ovf=1.
3. MULT -16*10 -> wrap: out_data=96, ovf=1; sat: -128, ovf=1. MULT 7*-3 -> -21, ovf=0.
4. DIV -7/2 -> out_data=-3, err=0, out_valid 9 cycles after accept, in_ready=0 during those cycles. DIV 7/0 -> out_data=0, err=1, latency 1.
5. DIV -128/-1 -> wrap: -128, ovf=1; sat: 127, ovf=1.
6. Backpressure: out_ready=0, issue ADD 1+2 then ADD 3+4 -> first result 3 held stable, in_ready=0. Raise out_ready -> 3 then 7 transferred in consecutive cycles, no loss or duplication. Also run 200 random transactions against a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the pipelined signed ALU (alu_pipe) and its
// iterative divider (alu_div_seq).
//   opcode_e    : 2-bit operation code (ADD=0, SUB=1, MULT=2, DIV=3)
//   alu_state_e : top-level control states
//   full_t      : wide signed container for full-precision intermediate results
//   sat_clamp   : wrap/saturate a full-precision result to a w-bit range
//   sign_fix    : apply the quotient sign to an unsigned magnitude
// The helpers take the target width as an argument so that one package serves
// every WIDTH instance; WIDTH is limited to MAX_WIDTH so a MULT product fits.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int FULL_W    = 64;
    localparam int MAX_WIDTH = FULL_W / 2;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_DIV  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } alu_state_e;

    typedef logic signed [FULL_W-1:0] full_t;

    // Largest representable value of a w-bit signed number.
    function automatic full_t max_val(input int unsigned w);
        return (full_t'(1) <<< (w - 1)) - full_t'(1);
    endfunction

    // Smallest representable value of a w-bit signed number.
    function automatic full_t min_val(input int unsigned w);
        return -(full_t'(1) <<< (w - 1));
    endfunction

    // True when v does not fit in a w-bit signed number.
    function automatic logic out_of_range(input full_t v, input int unsigned w);
        return (v > max_val(w)) || (v < min_val(w));
    endfunction

    // Saturate mode clamps to MIN/MAX by the true sign; wrap mode returns v
    // unchanged and the caller keeps only the low w bits.
    function automatic full_t sat_clamp(input full_t v, input int unsigned w,
                                        input logic sat);
        if (sat && out_of_range(v, w)) begin
            return (v < 0) ? min_val(w) : max_val(w);
        end
        return v;
    endfunction

    // The divider works on magnitudes; this restores the quotient sign.
    function automatic full_t sign_fix(input full_t mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/alu_div_seq.sv
// -----------------------------------------------------------------------------
// alu_div_seq
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-high reset (aborts any division)
//   start     : load dividend/divisor; the first iteration runs on this edge
//   dividend  : WIDTH-bit unsigned dividend
//   divisor   : WIDTH-bit unsigned divisor (caller guarantees non-zero)
//   busy      : iterations still outstanding
//   done      : one-cycle pulse WIDTH cycles after the start cycle; quotient
//               is final while done is high and stays until the next start
//   quotient  : WIDTH-bit unsigned quotient
// -----------------------------------------------------------------------------
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Iteration operands: on start the step works straight from the inputs so
    // the first quotient bit is produced on the start edge itself.
    logic [WIDTH-1:0] src_rem, src_quo, src_div;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] step_rem, step_quo;

    always_comb begin
        src_rem = start ? '0       : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor  : div_q;

        // Bring down the next dividend bit, try to subtract the divisor and
        // restore if the trial went negative.
        shifted = {src_rem, src_quo[WIDTH-1]};
        trial   = shifted - {1'b0, src_div};
        if (!trial[WIDTH]) begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {src_quo[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_quo = {src_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            div_d  = divisor;
            cnt_d  = CNT_W'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked signed ALU: ADD/SUB/MULT in one cycle, DIV through alu_div_seq.
// Per-transaction wrap/saturate, overflow and divide-by-zero flags.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/ready   : request handshake (in_ready low during reset and DIV)
//   in_opcode        : opcode_e
//   in_sat           : 1 = saturate on overflow, 0 = wrap
//   in_a, in_b       : WIDTH-bit signed operands
//   out_valid/ready  : result handshake; result held stable while stalled
//   out_data         : WIDTH-bit signed result
//   out_ovf          : true result not representable in WIDTH bits
//   out_err          : divide by zero (out_ovf is 0 when set)
// WIDTH must be in [4, MAX_WIDTH].
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_opcode,
    input  logic             in_sat,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_err
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;
    logic             neg_q, neg_d;   // quotient sign of the running DIV
    logic             sat_q, sat_d;   // saturate flag of the running DIV

    opcode_e          op;
    full_t            a_ext, b_ext, arith_full, div_full;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quotient;
    logic             out_room;

    assign op = opcode_e'(in_opcode);

    assign a_ext = $signed({{(FULL_W-WIDTH){in_a[WIDTH-1]}}, in_a});
    assign b_ext = $signed({{(FULL_W-WIDTH){in_b[WIDTH-1]}}, in_b});

    // Magnitudes for the unsigned divider; MIN maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits.
    assign a_mag = in_a[WIDTH-1] ? -in_a : in_a;
    assign b_mag = in_b[WIDTH-1] ? -in_b : in_b;

    // Single-cycle datapath at full precision; overflow and clamping are
    // judged on this value so both modes see the true result.
    always_comb begin
        case (op)
            OP_ADD:  arith_full = a_ext + b_ext;
            OP_SUB:  arith_full = a_ext - b_ext;
            OP_MULT: arith_full = a_ext * b_ext;
            default: arith_full = '0;
        endcase
    end

    assign div_full = sign_fix($signed({{(FULL_W-WIDTH){1'b0}}, div_quotient}),
                               neg_q);

    // The output register can take a new result when empty or being drained.
    assign out_room = !out_valid_q || out_ready;
    assign in_ready = (state_q == IDLE) && out_room && !rst;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        neg_d       = neg_q;
        sat_d       = sat_q;
        div_start   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (op == OP_DIV) begin
                        if (in_b == '0) begin
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            out_ovf_d   = 1'b0;
                            out_err_d   = 1'b1;
                        end else begin
                            div_start = 1'b1;
                            neg_d     = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                            sat_d     = in_sat;
                            state_d   = DIV_BUSY;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = WIDTH'(sat_clamp(arith_full, WIDTH, in_sat));
                        out_ovf_d   = out_of_range(arith_full, WIDTH);
                        out_err_d   = 1'b0;
                    end
                end
            end
            DIV_BUSY: begin
                if (div_done && !div_busy) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // Only MIN / -1 can overflow here.
                if (out_room) begin
                    out_valid_d = 1'b1;
                    out_data_d  = WIDTH'(sat_clamp(div_full, WIDTH, sat_q));
                    out_ovf_d   = out_of_range(div_full, WIDTH);
                    out_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            neg_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
            neg_q       <= neg_d;
            sat_q       <= sat_d;
        end
    end

    alu_div_seq #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe (WIDTH=8): directed cases plus 200 random
// transactions scored against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 8;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_opcode;
    logic         in_sat;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         out_err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_sat    (in_sat),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] data;
        logic                ovf;
        logic                err;
    } res_t;

    res_t   exp_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     res_cnt = 0;
    longint last_data = 0;
    bit     acc_flag;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: true result from plain integer arithmetic, then the
    // representability / wrap / saturate rules.
    function automatic res_t model(input logic [1:0] op, input logic sat,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, t;
        res_t   r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.err = 1'b0;
        t = 0;
        case (op)
            2'd0: t = sa + sb;
            2'd1: t = sa - sb;
            2'd2: t = sa * sb;
            default: begin
                if (sb == 0) begin
                    r.data = '0;
                    r.ovf  = 1'b0;
                    r.err  = 1'b1;
                    return r;
                end
                t = sa / sb;
            end
        endcase
        r.ovf = (t > MAXV) || (t < MINV);
        if (sat && r.ovf) r.data = (t < 0) ? W'(MINV) : W'(MAXV);
        else              r.data = t[W-1:0];
        return r;
    endfunction

    // One clock: judge handshakes at negedge+1, then advance to next negedge.
    task automatic tick();
        res_t e;
        acc_flag = 1'b0;
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_opcode, in_sat, in_a, in_b));
            acc_flag = 1'b1;
        end
        if (out_valid && out_ready) begin
            check_val("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("sb_data", $signed(out_data), e.data);
                check_val("sb_ovf", out_ovf, e.ovf);
                check_val("sb_err", out_err, e.err);
            end
            last_data = $signed(out_data);
            res_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic sat,
                         input longint a, input longint b);
        int n = 0;
        in_opcode = op;
        in_sat    = sat;
        in_a      = W'(a);
        in_b      = W'(b);
        in_valid  = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 50);
        if (!acc_flag) check_val("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Cycles after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] op,
                            input logic sat, input longint a, input longint b,
                            input longint e_data, input logic e_ovf,
                            input logic e_err, input int e_lat);
        int lat;
        bit rdy_seen;
        out_ready = 1'b1;
        issue(op, sat, a, b);
        wait_out(lat, rdy_seen);
        check_val({tag, "_lat"}, lat, e_lat);
        check_val({tag, "_ready_low"}, rdy_seen, 0);
        check_val({tag, "_data"}, $signed(out_data), e_data);
        check_val({tag, "_ovf"}, out_ovf, e_ovf);
        check_val({tag, "_err"}, out_err, e_err);
        $display("op=%0d sat=%0d a=%0d b=%0d -> data=%0d ovf=%0d err=%0d lat=%0d",
                 op, sat, a, b, $signed(out_data), out_ovf, out_err, lat);
        tick();
    endtask

    function automatic longint pick_operand();
        longint edge_v[5];
        edge_v = '{MINV, MAXV, 0, -1, 1};
        if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 4)];
        return longint'($signed(W'($urandom())));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     sent;
        int     budget;
        int     cnt0;
        bit     seen;
        longint ra, rb;

        rst = 1'b1;
        in_valid = 1'b0;
        in_opcode = 2'd0;
        in_sat = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_ovf", out_ovf, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a division
        issue(2'd3, 1'b0, 100, 3);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_val("midrst_in_ready", in_ready, 0);
        check_val("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_val("postrst_in_ready", in_ready, 1);
        check_val("postrst_out_data", out_data, 0);
        seen = 1'b0;
        repeat (12) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check_val("postrst_no_result", seen, 0);
        $display("reset mid-division: in_ready=%0d out_valid=%0d", in_ready, out_valid);
        op_check("add_after_rst", 2'd0, 1'b0, 1, 1, 2, 1'b0, 1'b0, 0);

        // Directed arithmetic
        op_check("add_wrap", 2'd0, 1'b0, 100, 50, -106, 1'b1, 1'b0, 0);
        op_check("add_sat", 2'd0, 1'b1, 100, 50, 127, 1'b1, 1'b0, 0);
        op_check("sub_sat", 2'd1, 1'b1, -100, 50, -128, 1'b1, 1'b0, 0);
        op_check("mul_wrap", 2'd2, 1'b0, -16, 10, 96, 1'b1, 1'b0, 0);
        op_check("mul_sat", 2'd2, 1'b1, -16, 10, -128, 1'b1, 1'b0, 0);
        op_check("mul_neg", 2'd2, 1'b0, 7, -3, -21, 1'b0, 1'b0, 0);
        op_check("div_neg", 2'd3, 1'b0, -7, 2, -3, 1'b0, 1'b0, W + 1);
        op_check("div_zero", 2'd3, 1'b0, 7, 0, 0, 1'b0, 1'b1, 0);
        op_check("div_min_wrap", 2'd3, 1'b0, -128, -1, -128, 1'b1, 1'b0, W + 1);
        op_check("div_min_sat", 2'd3, 1'b1, -128, -1, 127, 1'b1, 1'b0, W + 1);

        // Backpressure: second request must wait, both results in order
        out_ready = 1'b0;
        issue(2'd0, 1'b0, 1, 2);
        in_opcode = 2'd0;
        in_sat = 1'b0;
        in_a = W'(3);
        in_b = W'(4);
        in_valid = 1'b1;
        repeat (3) begin
            tick();
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_valid_held", out_valid, 1);
            check_val("bp_data_held", $signed(out_data), 3);
        end
        out_ready = 1'b1;
        cnt0 = res_cnt;
        tick();
        if (acc_flag) in_valid = 1'b0;
        check_val("bp_first_count", res_cnt - cnt0, 1);
        check_val("bp_first_data", last_data, 3);
        tick();
        in_valid = 1'b0;
        check_val("bp_second_count", res_cnt - cnt0, 2);
        check_val("bp_second_data", last_data, 7);
        $display("backpressure: results 3 then %0d", last_data);
        tick();

        // Random traffic with random backpressure
        sent = 0;
        budget = 0;
        while ((sent < 200 || exp_q.size() > 0 || out_valid) && budget < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
                ra = pick_operand();
                rb = pick_operand();
                in_opcode = 2'($urandom_range(0, 3));
                in_sat = 1'($urandom_range(0, 1));
                in_a = W'(ra);
                in_b = W'(rb);
                in_valid = 1'b1;
            end
            tick();
            if (acc_flag) begin
                in_valid = 1'b0;
                sent++;
            end
            budget++;
        end
        check_val("rand_sent", sent, 200);
        check_val("rand_drained", exp_q.size(), 0);
        $display("random: %0d transactions, %0d results total", sent, res_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
